rf_write_scheduler: RTL and testbench
=====================================

Name: rf_write_scheduler

Overview:
- Owns the single write port (A3/WD3/WE) of an integer or float register_file instance.
- Shares that port between the in-order pipeline writeback stage and one multi-cycle unit (divider or FPU) through a small result FIFO.
- Keeps a pending-write scoreboard and produces the decode stall for RAW/WAW hazards against outstanding multi-cycle results.
- Sits between the writeback stage, the multi-cycle unit and the register file.

Parameters:
ZERO_REG, 1, 1: register 0 is hardwired zero (never busy, writes dropped); 0: register 0 is ordinary.
FIFO_DEPTH, 2, multi-cycle result FIFO entries; power of two, at least 2.
STARVE_LIMIT, 8, cycles a non-empty FIFO head may wait before it preempts writeback; at least 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
wb_valid  in  1  pipeline writeback request
wb_rd  in  5  writeback destination
wb_data  in  32  writeback data
wb_stall  out  1  writeback stage must hold this cycle and retry
mc_issue  in  1  multi-cycle op issued this cycle (decode stage, not stalled)
mc_issue_rd  in  5  its destination
mc_valid  in  1  multi-cycle result valid
mc_rd  in  5  result destination
mc_data  in  32  result data
mc_ready  out  1  FIFO can accept a result
dec_valid  in  1  decode holds a valid instruction
dec_rs1, dec_rs2, dec_rd  in  5 each  decode operands
dec_use_rs1, dec_use_rs2, dec_we  in  1 each  operand and destination used
dec_stall  out  1  hazard against a busy register
rf_we  out  1  to register_file WE
rf_a3  out  5  to register_file A3
rf_wd  out  32  to register_file WD3

Behaviour:
- Reset (async, any time): FIFO empty, busy[31:0]=0, starve counter=0, in-flight results discarded.
  - While rst=1: rf_we=0, wb_stall=0, dec_stall=0, mc_ready=1, rf_a3=0, rf_wd=0.
  - mc_issue and mc_valid are ignored while rst=1.
- FIFO push: on a clk edge when mc_valid and mc_ready.
  - mc_ready = (count < FIFO_DEPTH), registered-state only; a full FIFO does not accept even when it pops in the same cycle.
  - Minimum latency mc_valid to rf_we is 1 cycle; there is no combinational pass-through.
- Write port selection (combinational from state and inputs):
  - preempt = FIFO non-empty and starve counter >= STARVE_LIMIT.
  - preempt=1: FIFO head drives rf_a3/rf_wd, pop; wb_stall = wb_valid.
  - Otherwise, wb_valid=1: wb drives the port; wb_stall=0.
  - Otherwise, FIFO non-empty: head drives the port, pop.
  - Otherwise: rf_we=0.
  - rf_we=1 when a source is selected, except ZERO_REG=1 with destination 0: rf_we=0, but a FIFO pop still occurs.
- Starve counter:
  - Cleared on every pop or when the FIFO is empty.
  - Otherwise increments each cycle the FIFO is non-empty and not popped; saturates at STARVE_LIMIT.
- Scoreboard:
  - mc_issue sets busy[mc_issue_rd]; never sets bit 0 when ZERO_REG=1.
  - A FIFO pop clears busy[head rd].
  - Set and clear of the same index in one cycle: set wins.
  - Issue to an already-busy rd never occurs because dec_stall covers WAW.
- dec_stall = dec_valid and (dec_use_rs1 and B[dec_rs1] or dec_use_rs2 and B[dec_rs2] or dec_we and B[dec_rd]).
  - B = busy with the bit of the register popped this cycle masked off, so the register file bypass supplies the value with no extra bubble.
- Pipeline contract: when wb_stall=1, the writeback stage holds wb_valid/wb_rd/wb_data stable to the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

Test Plan:
- Reset, then mc_issue rd=5; next cycle decode reads rs1=5 -> dec_stall=1. mc result rd=5 data=0xDEADBEEF with wb_valid=0 -> rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF one cycle after push. dec_stall=0 in that same write cycle; busy[5]=0 after the edge.
- Same cycle: wb_valid rd=3 data=0x11 and FIFO head rd=7 -> rf writes rd=3. rd=7 is written on the first cycle with wb_valid=0.
- wb_valid held 1 continuously with FIFO non-empty, STARVE_LIMIT=8 -> after 8 waiting cycles: wb_stall=1 and rf writes the FIFO head. The held wb write completes the next cycle.
- Push 2 results without popping (wb_valid=1, limit not reached) -> mc_ready=0; a third mc_valid is not accepted. mc_ready returns 1 the cycle after a pop.
- ZERO_REG=1: mc_issue rd=0 -> busy stays 0, no stall. A result to rd=0 pops with rf_we=0.
- Assert rst mid-operation with 2 FIFO entries and busy[9]=1 -> immediately rf_we=0, mc_ready=1, dec_stall=0. After release, no stale write occurs.

Source files
------------

// File: rtl/rf_write_scheduler.sv
// Register-file write-port arbiter: shares one write port between the writeback stage and a
// multi-cycle unit's result FIFO, and tracks outstanding multi-cycle destinations for decode stalls.
module rf_write_scheduler #(
    parameter int ZERO_REG     = 1,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        mc_issue,
    input  logic [4:0]  mc_issue_rd,
    input  logic        mc_valid,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_use_rs1,
    input  logic        dec_use_rs2,
    input  logic        dec_we,
    output logic        dec_stall,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
    localparam logic          ZERO_C  = (ZERO_REG != 0);

    logic [4:0]    rd_mem   [FIFO_DEPTH];
    logic [31:0]   data_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] starve;
    logic [31:0]   busy;

    logic          empty, not_full, preempt, sel_fifo, sel_wb, pop, push;
    logic [4:0]    head_rd, dest;
    logic [31:0]   head_data, wdata, clr_mask, set_mask, busy_eff;

    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        empty     = (count == '0);
        not_full  = (count < DEPTH_C);
        head_rd   = rd_mem[rd_ptr];
        head_data = data_mem[rd_ptr];
        preempt   = !empty && (starve >= LIMIT_C);
        sel_fifo  = !empty && (preempt || !wb_valid);
        sel_wb    = wb_valid && !sel_fifo;
        pop       = sel_fifo && !rst;
        push      = mc_valid && not_full && !rst;
        dest      = sel_fifo ? head_rd   : wb_rd;
        wdata     = sel_fifo ? head_data : wb_data;
        clr_mask  = pop ? (32'd1 << head_rd) : 32'd0;
        set_mask  = (mc_issue && !rst && !(ZERO_C && mc_issue_rd == 5'd0))
                    ? (32'd1 << mc_issue_rd) : 32'd0;
        // A register popped this cycle is forwarded by the register file, so it no longer blocks decode.
        busy_eff  = busy & ~clr_mask;
    end

    always_comb begin
        mc_ready  = rst || not_full;
        wb_stall  = !rst && preempt && wb_valid;
        rf_we     = !rst && (sel_fifo || sel_wb) && !(ZERO_C && dest == 5'd0);
        rf_a3     = rst ? 5'd0  : dest;
        rf_wd     = rst ? 32'd0 : wdata;
        dec_stall = !rst && dec_valid &&
                    ((dec_use_rs1 && busy_eff[dec_rs1]) ||
                     (dec_use_rs2 && busy_eff[dec_rs2]) ||
                     (dec_we      && busy_eff[dec_rd]));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            starve <= '0;
            busy   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (pop || empty)
                starve <= '0;
            else if (starve < LIMIT_C)
                starve <= starve + 1'b1;
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    // NOTE: FIFO storage has no reset; count gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= mc_rd;
            data_mem[wr_ptr] <= mc_data;
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_rf_write_scheduler;

    localparam int ZERO_REG     = 1;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mc_issue;
    logic [4:0]  mc_issue_rd;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        dec_valid;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_use_rs1, dec_use_rs2, dec_we;
    logic        dec_stall;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    int tests_run = 0;
    int tests_failed = 0;

    rf_write_scheduler #(
        .ZERO_REG(ZERO_REG), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_we(dec_we),
        .dec_stall(dec_stall),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results waiting for the port, pending destinations, and head waiting time.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } result_t;

    result_t     q[$];
    bit          busy_m [32];
    int          wait_m;
    logic        exp_wb_stall = 1'b0;

    always @(negedge clk) begin : model
        bit          have_head, use_fifo, use_wb, we_e, ready_e, stall_e;
        result_t     head;
        logic [4:0]  dst;
        logic [31:0] dat;
        bit          blocked [32];

        if (rst) begin
            check("rst_rf_we", rf_we, 0);
            check("rst_rf_a3", rf_a3, 0);
            check("rst_rf_wd", rf_wd, 0);
            check("rst_wb_stall", wb_stall, 0);
            check("rst_dec_stall", dec_stall, 0);
            check("rst_mc_ready", mc_ready, 1);
            q.delete();
            foreach (busy_m[i]) busy_m[i] = 0;
            wait_m = 0;
            exp_wb_stall = 1'b0;
        end else begin
            have_head = (q.size() > 0);
            if (have_head) head = q[0];
            use_fifo = have_head && (wait_m >= STARVE_LIMIT || !wb_valid);
            use_wb   = wb_valid && !use_fifo;
            exp_wb_stall = wb_valid && use_fifo;
            dst = use_fifo ? head.rd   : wb_rd;
            dat = use_fifo ? head.data : wb_data;
            we_e = (use_fifo || use_wb) && !(ZERO_REG != 0 && dst == 5'd0);
            ready_e = (q.size() < FIFO_DEPTH);

            blocked = busy_m;
            if (use_fifo) blocked[head.rd] = 0;
            stall_e = dec_valid && ((dec_use_rs1 && blocked[dec_rs1]) ||
                                    (dec_use_rs2 && blocked[dec_rs2]) ||
                                    (dec_we && blocked[dec_rd]));

            check("m_rf_we", rf_we, we_e);
            if (we_e) begin
                check("m_rf_a3", rf_a3, dst);
                check("m_rf_wd", rf_wd, dat);
            end
            check("m_wb_stall", wb_stall, exp_wb_stall);
            check("m_mc_ready", mc_ready, ready_e);
            check("m_dec_stall", dec_stall, stall_e);

            // Advance to the state that the next rising edge will produce.
            if (use_fifo || !have_head) wait_m = 0;
            else if (wait_m < STARVE_LIMIT) wait_m++;
            if (use_fifo) begin
                busy_m[head.rd] = 0;
                void'(q.pop_front());
            end
            if (mc_valid && ready_e) q.push_back('{rd: mc_rd, data: mc_data});
            if (mc_issue && !(ZERO_REG != 0 && mc_issue_rd == 5'd0)) busy_m[mc_issue_rd] = 1;
        end
    end

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        mc_issue = 0; mc_issue_rd = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_use_rs1 = 0; dec_use_rs2 = 0; dec_we = 0;
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1;
        idle();
        #3;
        check("reset_rf_we", rf_we, 0);
        check("reset_mc_ready", mc_ready, 1);
        check("reset_dec_stall", dec_stall, 0);
        check("reset_wb_stall", wb_stall, 0);
        cyc(); rst = 0;

        // RAW stall, then write one cycle after push with the stall released in the write cycle.
        cyc(); mc_issue = 1; mc_issue_rd = 5;
        cyc(); mc_issue = 0; dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5;
        mc_valid = 1; mc_rd = 5; mc_data = 32'hDEADBEEF;
        settle();
        check("raw_stall", dec_stall, 1);
        cyc(); mc_valid = 0;
        settle();
        check("mc_write_we", rf_we, 1);
        check("mc_write_a3", rf_a3, 5);
        check("mc_write_wd", rf_wd, 32'hDEADBEEF);
        check("bypass_no_stall", dec_stall, 0);
        cyc();
        settle();
        check("busy_cleared", dec_stall, 0);
        check("idle_no_write", rf_we, 0);
        idle();

        // Writeback wins over a waiting FIFO head.
        cyc(); mc_valid = 1; mc_rd = 7; mc_data = 32'h77;
        cyc(); mc_valid = 0; wb_valid = 1; wb_rd = 3; wb_data = 32'h11;
        settle();
        check("wb_priority_a3", rf_a3, 3);
        check("wb_priority_wd", rf_wd, 32'h11);
        cyc(); wb_valid = 0;
        settle();
        check("fifo_after_wb_a3", rf_a3, 7);
        check("fifo_after_wb_wd", rf_wd, 32'h77);

        // Starvation: after STARVE_LIMIT waiting cycles the head preempts writeback.
        cyc(); mc_valid = 1; mc_rd = 12; mc_data = 32'hC; wb_valid = 1; wb_rd = 4; wb_data = 32'h44;
        settle();
        check("starve_push_wb_a3", rf_a3, 4);
        cyc(); mc_valid = 0;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            settle();
            check("starve_wait_stall", wb_stall, 0);
            check("starve_wait_a3", rf_a3, 4);
            cyc();
        end
        settle();
        check("preempt_stall", wb_stall, 1);
        check("preempt_a3", rf_a3, 12);
        check("preempt_wd", rf_wd, 32'hC);
        cyc();
        settle();
        check("held_wb_stall", wb_stall, 0);
        check("held_wb_a3", rf_a3, 4);
        check("held_wb_wd", rf_wd, 32'h44);

        // Full FIFO: third result refused, ready returns the cycle after a pop.
        cyc(); mc_valid = 1; mc_rd = 20; mc_data = 1;
        settle(); check("fill0_ready", mc_ready, 1);
        cyc(); mc_rd = 21; mc_data = 2;
        settle(); check("fill1_ready", mc_ready, 1);
        cyc(); mc_rd = 22; mc_data = 3;
        settle(); check("full_ready", mc_ready, 0);
        cyc(); mc_valid = 0; wb_valid = 0;
        settle();
        check("full_pop_a3", rf_a3, 20);
        check("full_pop_ready", mc_ready, 0);
        cyc();
        settle();
        check("after_pop_ready", mc_ready, 1);
        check("second_pop_a3", rf_a3, 21);
        cyc();
        settle();
        check("third_dropped", rf_we, 0);
        idle();

        // Register zero: never busy, results popped silently.
        cyc(); mc_issue = 1; mc_issue_rd = 0;
        cyc(); mc_issue = 0; dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 0;
        mc_valid = 1; mc_rd = 0; mc_data = 32'h55;
        settle(); check("zero_no_stall", dec_stall, 0);
        cyc(); mc_rd = 8; mc_data = 32'h88;
        settle(); check("zero_no_we", rf_we, 0);
        cyc(); mc_valid = 0;
        settle();
        check("after_zero_a3", rf_a3, 8);
        check("after_zero_we", rf_we, 1);
        idle();

        // Reset mid-operation with two entries queued and busy[9] set.
        cyc(); wb_valid = 1; wb_rd = 1; wb_data = 32'h1;
        mc_issue = 1; mc_issue_rd = 9; mc_valid = 1; mc_rd = 9; mc_data = 32'h99;
        cyc(); mc_issue = 0; mc_rd = 10; mc_data = 32'hAA;
        cyc(); mc_valid = 0; dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 9;
        settle();
        check("pre_rst_stall", dec_stall, 1);
        check("pre_rst_ready", mc_ready, 0);
        rst = 1;
        settle();
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_ready", mc_ready, 1);
        check("mid_rst_dec_stall", dec_stall, 0);
        cyc(); rst = 0; wb_valid = 0;
        settle();
        check("post_rst_no_write", rf_we, 0);
        check("post_rst_no_stall", dec_stall, 0);
        cyc();
        settle();
        check("post_rst_no_stale", rf_we, 0);
        idle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst = ($urandom_range(0, 149) == 0);
            if (!exp_wb_stall) begin
                wb_valid = ($urandom_range(0, 9) < 6);
                wb_rd    = 5'($urandom_range(0, 7));
                wb_data  = $urandom;
            end
            mc_valid = ($urandom_range(0, 9) < 4);
            mc_rd    = 5'($urandom_range(0, 7));
            mc_data  = $urandom;
            mc_issue_rd = 5'($urandom_range(0, 7));
            mc_issue = ($urandom_range(0, 9) < 3) && !busy_m[mc_issue_rd];
            dec_valid = mc_issue || ($urandom_range(0, 9) < 7);
            dec_rs1 = 5'($urandom_range(0, 7));
            dec_rs2 = 5'($urandom_range(0, 7));
            dec_rd  = mc_issue ? mc_issue_rd : 5'($urandom_range(0, 7));
            dec_use_rs1 = !mc_issue && $urandom_range(0, 1) == 1;
            dec_use_rs2 = !mc_issue && $urandom_range(0, 1) == 1;
            dec_we      = mc_issue || $urandom_range(0, 1) == 1;
        end

        cyc();
        idle();
        rst = 0;
        repeat (3) cyc();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
